// File: rtl/elpis_print_bridge.sv
// Print-word FIFO between the Elpis core and the Caravel Wishbone bus.
// Optional IRQ output and enable bit are built when ELPIS_PRINT_IRQ_EN is defined.
module elpis_print_bridge #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        print_valid_i,
    input  logic [31:0] print_data_i,
    output logic        print_ready_o,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
`ifdef ELPIS_PRINT_IRQ_EN
    output logic        irq_o,
`endif
    output logic        la_print_pending_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count, count_d;
    logic          full, empty, push, pop, flush, accept, hit;
    logic          underflow_q, underflow_d;
    logic          pending_q;
    logic [31:0]   dat_q, dat_d, rd_data, status_word;
    logic [1:0]    reg_off;
    logic          irq_en_bit;
    logic          unused_bits;

    assign count         = wptr_q - rptr_q;
    assign full          = (count == (AW+1)'(DEPTH));
    assign empty         = (count == '0);
    assign push          = print_valid_i & ~full;
    assign hit           = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_off       = wbs_adr_i[3:2];
    assign accept        = (state_q == S_IDLE) & wbs_cyc_i & wbs_stb_i & hit;
    assign unused_bits   = ^{wbs_dat_i[31:3], wbs_sel_i[3:1], wbs_adr_i[1:0]};

`ifdef ELPIS_PRINT_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;
    assign irq_en_bit = irq_en_q;
    assign irq_o      = irq_q;
`else
    assign irq_en_bit = 1'b0;
`endif

    assign status_word = {16'(count), 12'b0, irq_en_bit, underflow_q, full, empty};

    // State register and all reset-sensitive datapath registers
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            underflow_q <= 1'b0;
            dat_q       <= '0;
            pending_q   <= 1'b0;
`ifdef ELPIS_PRINT_IRQ_EN
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            underflow_q <= underflow_d;
            dat_q       <= dat_d;
            pending_q   <= (count_d != '0);
`ifdef ELPIS_PRINT_IRQ_EN
            irq_en_q    <= irq_en_d;
            irq_q       <= (count_d != '0) & irq_en_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= print_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus side effects are taken on the accepting edge; the ACK cycle only presents them
    always_comb begin
        pop         = 1'b0;
        flush       = 1'b0;
        rd_data     = '0;
        underflow_d = underflow_q;
        dat_d       = dat_q;
`ifdef ELPIS_PRINT_IRQ_EN
        irq_en_d    = irq_en_q;
`endif
        if (accept) begin
            if (!wbs_we_i) begin
                case (reg_off)
                    2'd0: begin
                        if (empty) begin
                            underflow_d = 1'b1;
                        end else begin
                            pop     = 1'b1;
                            rd_data = mem_q[rptr_q[AW-1:0]];
                        end
                    end
                    2'd1:    rd_data = status_word;
                    default: rd_data = '0;
                endcase
                dat_d = rd_data;
            end else if (reg_off == 2'd2 && wbs_sel_i[0]) begin
                flush = wbs_dat_i[0];
                if (wbs_dat_i[1]) underflow_d = 1'b0;
`ifdef ELPIS_PRINT_IRQ_EN
                irq_en_d = wbs_dat_i[2];
`endif
            end
        end
        // Flush discards what is already stored; a word pushed on the same edge survives
        rptr_d  = flush ? wptr_q : rptr_q + (AW+1)'(pop);
        wptr_d  = wptr_q + (AW+1)'(push);
        count_d = wptr_d - rptr_d;
    end

    always_comb begin
        wbs_ack_o          = (state_q == S_ACK);
        wbs_dat_o          = dat_q;
        print_ready_o      = ~full;
        la_print_pending_o = pending_q;
    end

endmodule
